// File: rtl/qei_core_if.sv
// Signal bundle between the QEI core and its wrapper.
// slave  : the core (takes raw encoder inputs and controls, drives results)
// master : the wrapper / testbench (drives inputs, observes results)
interface qei_core_if #(
  parameter int unsigned CNT_W = 16
);
  logic             enc_a;
  logic             enc_b;
  logic             enc_z;
  logic [1:0]       mode;
  logic             idx_clr_en;
  logic             clr;
  logic [CNT_W-1:0] count;
  logic             dir;
  logic             step;
  logic             err;
  logic [CNT_W-1:0] idx_latch;
  logic             idx_seen;
  logic [CNT_W-1:0] velocity;
  logic             vel_valid;

  modport slave (
    input  enc_a, enc_b, enc_z, mode, idx_clr_en, clr,
    output count, dir, step, err, idx_latch, idx_seen, velocity, vel_valid
  );

  modport master (
    output enc_a, enc_b, enc_z, mode, idx_clr_en, clr,
    input  count, dir, step, err, idx_latch, idx_seen, velocity, vel_valid
  );
endinterface

// File: rtl/qei_core.sv
// Quadrature encoder interface core.
// Synchronises and glitch-filters raw A/B/Z, decodes x4/x2/x1 into a wrapping
// position counter, tracks direction, flags illegal transitions, captures the
// count on index and measures net counts per fixed window (velocity).
// Ports:
//   clk   : system clock, all state on posedge
//   rst_n : asynchronous active-low reset
//   bus   : qei_core_if slave modport (encoder inputs, controls, results)
module qei_core #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FILT_LEN   = 4,
  parameter int unsigned VEL_PERIOD = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  qei_core_if.slave   bus
);

  localparam int unsigned FiltW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int unsigned WinW  = $clog2(VEL_PERIOD);
  localparam logic [FiltW-1:0] FiltLast = FiltW'(FILT_LEN - 1);
  localparam logic [WinW-1:0]  WinLast  = WinW'(VEL_PERIOD - 1);

  // Channel bit order in the input path: [2] = A, [1] = B, [0] = Z.
  logic [2:0]            sync1_q, sync2_q;
  logic [2:0]            filt_q, filt_d;
  logic [2:0][FiltW-1:0] fcnt_q, fcnt_d;

  logic [1:0]       ab_prev_q;
  logic             z_prev_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] idx_latch_q, idx_latch_d;
  logic             idx_seen_q, idx_seen_d;
  logic [CNT_W-1:0] vel_acc_q, vel_acc_d;
  logic [CNT_W-1:0] velocity_q, velocity_d;
  logic             vel_valid_q, vel_valid_d;
  logic [WinW-1:0]  win_q, win_d;

  // Forward successor of a {A,B} state: 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] fwd_of(input logic [1:0] s);
    logic [1:0] r;
    unique case (s)
      2'b00:   r = 2'b01;
      2'b01:   r = 2'b11;
      2'b11:   r = 2'b10;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  // Filter: the counter restarts whenever the synced sample agrees with the
  // accepted level, so only FILT_LEN consecutive disagreeing samples flip it.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] == filt_q[i]) begin
        fcnt_d[i] = '0;
      end else if (fcnt_q[i] == FiltLast) begin
        filt_d[i] = ~filt_q[i];
        fcnt_d[i] = '0;
      end else begin
        fcnt_d[i] = fcnt_q[i] + 1'b1;
      end
    end
  end

  logic [1:0]       ab;
  logic             z_rise;
  logic             moved, illegal, legal, is_fwd, active, counted;
  logic [CNT_W-1:0] cnt_step;
  logic [CNT_W-1:0] acc_sum;

  always_comb begin
    ab      = filt_q[2:1];
    z_rise  = filt_q[0] & ~z_prev_q;
    moved   = (ab != ab_prev_q);
    illegal = ((ab ^ ab_prev_q) == 2'b11);
    legal   = moved & ~illegal;
    is_fwd  = (ab == fwd_of(ab_prev_q));
    active  = (bus.mode != 2'b11);

    unique case (bus.mode)
      2'b00:   counted = legal;
      2'b01:   counted = legal & (ab[1] != ab_prev_q[1]);
      2'b10:   counted = legal & (((ab_prev_q == 2'b01) & (ab == 2'b11)) |
                                  ((ab_prev_q == 2'b11) & (ab == 2'b01)));
      default: counted = 1'b0;
    endcase

    if (!counted)    cnt_step = '0;
    else if (is_fwd) cnt_step = CNT_W'(1);
    else             cnt_step = '1;

    // Count: clr beats index clear beats the decoded step.
    count_d = count_q + cnt_step;
    if (bus.clr)                          count_d = '0;
    else if (z_rise && bus.idx_clr_en)    count_d = '0;
    step_d = (count_d != count_q);

    dir_d = dir_q;
    if (active && legal) dir_d = is_fwd;

    err_d = err_q;
    if (bus.clr)                  err_d = 1'b0;
    else if (active && illegal)   err_d = 1'b1;

    idx_latch_d = idx_latch_q;
    idx_seen_d  = idx_seen_q;
    if (bus.clr) begin
      idx_latch_d = '0;
      idx_seen_d  = 1'b0;
    end else if (z_rise) begin
      idx_latch_d = count_q;
      idx_seen_d  = 1'b1;
    end

    // Velocity counts real motion only; clr and index clears are ignored.
    acc_sum     = vel_acc_q + cnt_step;
    velocity_d  = velocity_q;
    vel_valid_d = 1'b0;
    if (win_q == WinLast) begin
      win_d       = '0;
      vel_acc_d   = '0;
      velocity_d  = acc_sum;
      vel_valid_d = 1'b1;
    end else begin
      win_d     = win_q + 1'b1;
      vel_acc_d = acc_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      filt_q      <= '0;
      fcnt_q      <= '0;
      ab_prev_q   <= '0;
      z_prev_q    <= 1'b0;
      count_q     <= '0;
      dir_q       <= 1'b0;
      step_q      <= 1'b0;
      err_q       <= 1'b0;
      idx_latch_q <= '0;
      idx_seen_q  <= 1'b0;
      vel_acc_q   <= '0;
      velocity_q  <= '0;
      vel_valid_q <= 1'b0;
      win_q       <= '0;
    end else begin
      sync1_q     <= {bus.enc_a, bus.enc_b, bus.enc_z};
      sync2_q     <= sync1_q;
      filt_q      <= filt_d;
      fcnt_q      <= fcnt_d;
      // Previous state always tracks, even in hold, so re-enabling is clean.
      ab_prev_q   <= ab;
      z_prev_q    <= filt_q[0];
      count_q     <= count_d;
      dir_q       <= dir_d;
      step_q      <= step_d;
      err_q       <= err_d;
      idx_latch_q <= idx_latch_d;
      idx_seen_q  <= idx_seen_d;
      vel_acc_q   <= vel_acc_d;
      velocity_q  <= velocity_d;
      vel_valid_q <= vel_valid_d;
      win_q       <= win_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.dir       = dir_q;
  assign bus.step      = step_q;
  assign bus.err       = err_q;
  assign bus.idx_latch = idx_latch_q;
  assign bus.idx_seen  = idx_seen_q;
  assign bus.velocity  = velocity_q;
  assign bus.vel_valid = vel_valid_q;

endmodule

// File: tb/tb_qei_core.sv
// Directed bench for qei_core: decoding table plus corner-case sequences.
module tb_qei_core;

  localparam int HOLD = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   step_seen = 0;

  always #5 clk = ~clk;

  qei_core_if #(.CNT_W(16)) bus ();

  qei_core #(
    .CNT_W(16),
    .FILT_LEN(4),
    .VEL_PERIOD(200)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always @(negedge clk) if (bus.step) step_seen++;

  typedef struct {
    logic [1:0]  ab;
    logic [1:0]  mode;
    logic [15:0] cnt;
    logic        dir;
    int          steps;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] fwd_next(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] bwd_next(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  logic [1:0] cur_ab = 2'b00;

  task automatic drive_ab(input logic [1:0] ab);
    @(negedge clk);
    bus.enc_a = ab[1];
    bus.enc_b = ab[0];
    cur_ab = ab;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
  endtask

  task automatic wait_vv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.vel_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int n;
    bus.enc_a = 0; bus.enc_b = 0; bus.enc_z = 0;
    bus.mode = 2'b00; bus.idx_clr_en = 0; bus.clr = 0;

    // x4 full cycle forward then back.
    vecs.push_back('{2'b01, 2'd0, 16'd1, 1'b1, 1});
    vecs.push_back('{2'b11, 2'd0, 16'd2, 1'b1, 1});
    vecs.push_back('{2'b10, 2'd0, 16'd3, 1'b1, 1});
    vecs.push_back('{2'b00, 2'd0, 16'd4, 1'b1, 1});
    vecs.push_back('{2'b10, 2'd0, 16'd3, 1'b0, 1});
    vecs.push_back('{2'b11, 2'd0, 16'd2, 1'b0, 1});
    vecs.push_back('{2'b01, 2'd0, 16'd1, 1'b0, 1});
    vecs.push_back('{2'b00, 2'd0, 16'd0, 1'b0, 1});
    // x2: B-only moves are uncounted but still set dir.
    vecs.push_back('{2'b01, 2'd1, 16'd0, 1'b1, 0});
    vecs.push_back('{2'b00, 2'd1, 16'd0, 1'b0, 0});
    vecs.push_back('{2'b01, 2'd1, 16'd0, 1'b1, 0});
    vecs.push_back('{2'b11, 2'd1, 16'd1, 1'b1, 1});
    vecs.push_back('{2'b10, 2'd1, 16'd1, 1'b1, 0});
    vecs.push_back('{2'b00, 2'd1, 16'd2, 1'b1, 1});
    // x1: only 01<->11 counts.
    vecs.push_back('{2'b01, 2'd2, 16'd2, 1'b1, 0});
    vecs.push_back('{2'b11, 2'd2, 16'd3, 1'b1, 1});
    vecs.push_back('{2'b01, 2'd2, 16'd2, 1'b0, 1});
    vecs.push_back('{2'b11, 2'd2, 16'd3, 1'b1, 1});
    vecs.push_back('{2'b10, 2'd2, 16'd3, 1'b1, 0});
    vecs.push_back('{2'b00, 2'd2, 16'd3, 1'b1, 0});
    vecs.push_back('{2'b10, 2'd2, 16'd3, 1'b0, 0});
    vecs.push_back('{2'b11, 2'd2, 16'd3, 1'b0, 0});
    vecs.push_back('{2'b01, 2'd2, 16'd2, 1'b0, 1});
    vecs.push_back('{2'b00, 2'd2, 16'd2, 1'b0, 0});
    // Hold: nothing moves; re-enable gives no spurious step.
    vecs.push_back('{2'b01, 2'd3, 16'd2, 1'b0, 0});
    vecs.push_back('{2'b11, 2'd3, 16'd2, 1'b0, 0});
    vecs.push_back('{2'b10, 2'd0, 16'd3, 1'b1, 1});
    vecs.push_back('{2'b00, 2'd0, 16'd4, 1'b1, 1});

    repeat (3) @(negedge clk);
    chk("reset count", 32'(bus.count), 32'd0);
    chk("reset dir", 32'(bus.dir), 32'd0);
    chk("reset step", 32'(bus.step), 32'd0);
    chk("reset err", 32'(bus.err), 32'd0);
    chk("reset idx_latch", 32'(bus.idx_latch), 32'd0);
    chk("reset idx_seen", 32'(bus.idx_seen), 32'd0);
    chk("reset velocity", 32'(bus.velocity), 32'd0);
    chk("reset vel_valid", 32'(bus.vel_valid), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      bus.mode = vecs[i].mode;
      step_seen = 0;
      drive_ab(vecs[i].ab);
      chk($sformatf("tbl[%0d] count", i), 32'(bus.count), 32'(vecs[i].cnt));
      chk($sformatf("tbl[%0d] dir", i), 32'(bus.dir), 32'(vecs[i].dir));
      chk($sformatf("tbl[%0d] steps", i), 32'(step_seen), 32'(vecs[i].steps));
    end

    pulse_clr();
    chk("clr count", 32'(bus.count), 32'd0);

    // x2, 8 forward cycles.
    bus.mode = 2'b01;
    for (int i = 0; i < 32; i++) drive_ab(fwd_next(cur_ab));
    chk("x2 fwd count", 32'(bus.count), 32'd16);

    // x1, 8 forward then 8 backward cycles.
    bus.mode = 2'b10;
    for (int i = 0; i < 32; i++) drive_ab(fwd_next(cur_ab));
    chk("x1 fwd count", 32'(bus.count), 32'd24);
    for (int i = 0; i < 32; i++) drive_ab(bwd_next(cur_ab));
    chk("x1 bwd count", 32'(bus.count), 32'd16);
    chk("x1 bwd dir", 32'(bus.dir), 32'd0);

    // Short glitch on A is rejected.
    bus.mode = 2'b00;
    step_seen = 0;
    @(negedge clk) bus.enc_a = 1'b1;
    @(negedge clk);
    @(negedge clk) bus.enc_a = 1'b0;
    repeat (12) @(negedge clk);
    chk("glitch count", 32'(bus.count), 32'd16);
    chk("glitch steps", 32'(step_seen), 32'd0);

    // Illegal 00 -> 11.
    drive_ab(2'b11);
    chk("illegal err", 32'(bus.err), 32'd1);
    chk("illegal count", 32'(bus.count), 32'd16);
    chk("illegal dir", 32'(bus.dir), 32'd0);
    pulse_clr();
    chk("clr err", 32'(bus.err), 32'd0);
    chk("clr count2", 32'(bus.count), 32'd0);

    // Wrap around both ways.
    drive_ab(bwd_next(cur_ab));
    chk("wrap down", 32'(bus.count), 32'hffff);
    drive_ab(fwd_next(cur_ab));
    chk("wrap up", 32'(bus.count), 32'h0000);
    drive_ab(bwd_next(cur_ab));
    chk("wrap down2", 32'(bus.count), 32'hffff);
    drive_ab(fwd_next(cur_ab));

    // Index capture with clear at count 37.
    for (int i = 0; i < 37; i++) drive_ab(fwd_next(cur_ab));
    chk("pre-index count", 32'(bus.count), 32'd37);
    bus.idx_clr_en = 1'b1;
    @(negedge clk) bus.enc_z = 1'b1;
    repeat (HOLD) @(negedge clk);
    chk("idx_latch", 32'(bus.idx_latch), 32'd37);
    chk("idx_seen", 32'(bus.idx_seen), 32'd1);
    chk("idx clear count", 32'(bus.count), 32'd0);
    @(negedge clk) bus.enc_z = 1'b0;
    repeat (HOLD) @(negedge clk);
    for (int i = 0; i < 3; i++) drive_ab(fwd_next(cur_ab));
    chk("pre-coincident count", 32'(bus.count), 32'd3);
    // Z and a forward step land in the same cycle: clear wins.
    @(negedge clk);
    bus.enc_z = 1'b1;
    cur_ab = fwd_next(cur_ab);
    bus.enc_a = cur_ab[1];
    bus.enc_b = cur_ab[0];
    repeat (HOLD) @(negedge clk);
    chk("coincident count", 32'(bus.count), 32'd0);
    chk("coincident latch", 32'(bus.idx_latch), 32'd3);
    @(negedge clk) bus.enc_z = 1'b0;
    bus.idx_clr_en = 1'b0;
    repeat (HOLD) @(negedge clk);

    // Velocity: 20 forward counts inside one window, then an idle window.
    wait_vv(ok);
    chk("vel_valid seen 0", 32'(ok), 32'd1);
    for (int i = 0; i < 20; i++) drive_ab(fwd_next(cur_ab));
    wait_vv(ok);
    chk("vel_valid seen 1", 32'(ok), 32'd1);
    chk("velocity 20", 32'(bus.velocity), 32'd20);
    @(negedge clk);
    chk("vel_valid one cycle", 32'(bus.vel_valid), 32'd0);
    wait_vv(ok);
    chk("vel_valid seen 2", 32'(ok), 32'd1);
    chk("velocity idle", 32'(bus.velocity), 32'd0);

    // Asynchronous reset mid-cycle.
    chk("pre-reset count", 32'(bus.count), 32'd20);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst count", 32'(bus.count), 32'd0);
    chk("async rst idx_seen", 32'(bus.idx_seen), 32'd0);
    chk("async rst dir", 32'(bus.dir), 32'd0);
    bus.enc_a = 1'b0;
    bus.enc_b = 1'b0;

    // First vel_valid comes VEL_PERIOD cycles after reset release.
    @(negedge clk) rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      n++;
      if (bus.vel_valid) break;
    end
    chk("first vel_valid cycle", 32'(n), 32'd200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/qei_core.md
# qei_core

Parametrised quadrature encoder interface core, the successor to the fixed x4, 16-bit QEI in our TinyTapeout wrapper. It synchronises and glitch-filters raw A/B/Z inputs and decodes them in x4, x2 or x1 mode into a CNT_W-bit position counter. It also provides direction, an illegal-transition flag, index capture/clear and a windowed velocity measurement. The wrapper instantiates it and maps the outputs onto `uo_out` / `uio_out`.

## Interface
- CNT_W, 16: width of position counter, index latch and velocity.
- FILT_LEN, 4: consecutive identical synchronised samples required to accept a new A/B/Z level (≥1).
- VEL_PERIOD, 1000: clock cycles per velocity window (≥2).

Ports:
- clk  in  1  system clock; all state on posedge.
- rst_n  in  1  reset; one clock, reset asynchronous active-low.
- enc_a  in  1  raw encoder A, asynchronous.
- enc_b  in  1  raw encoder B, asynchronous.
- enc_z  in  1  raw index Z, asynchronous.
- mode  in  2  00 = x4, 01 = x2, 10 = x1, 11 = hold (no counting).
- idx_clr_en  in  1  when 1, a filtered Z rising edge clears count.
- clr  in  1  synchronous clear of count, err, idx_latch, idx_seen.
- count  out  CNT_W  position, modulo 2^CNT_W.
- dir  out  1  last legal transition direction: 1 = forward, 0 = backward.
- step  out  1  one-cycle pulse on every count change.
- err  out  1  sticky illegal-transition flag.
- idx_latch  out  CNT_W  count captured at last filtered Z rising edge.
- idx_seen  out  1  sticky; set on first Z rising edge.
- velocity  out  CNT_W  signed net counts in last completed window.
- vel_valid  out  1  one-cycle pulse when velocity updates.

## Operation
- Input path per channel: 2-FF synchroniser, then filter. Filter counter resets whenever the synced sample equals the filtered level. Filtered level flips after FILT_LEN consecutive differing samples.
- Decoder state S = {A,B} (filtered), with previous state P registered.
- Forward sequence: 00→01→11→10→00. Backward is the reverse.
- x4: every legal transition counts ±1.
- x2: only transitions where A changes count: 01→11, 10→00 give +1; 11→01, 00→10 give −1.
- x1: only 01→11 (+1) and 11→01 (−1).
- dir updates on every legal transition in modes 00–10, whether or not it is counted.
- Illegal transition (A and B both change in the same cycle): count and dir unchanged, no step, err ← 1.
- Hold mode (11): P keeps tracking S, so re-enabling produces no spurious step. No count, dir, err or velocity change.
- Mode changes take effect on the next transition.
- Index: on filtered Z 0→1, idx_latch ← count (pre-update value) and idx_seen ← 1. If idx_clr_en = 1, count ← 0.
- Priority in one cycle: clr > index clear > step. A dropped step still pulses step only if count changes.
- Arithmetic: count and velocity wrap modulo 2^CNT_W. No saturation.
- Velocity: window counter runs 0..VEL_PERIOD−1. Accumulator sums each counted ±1.
- In the terminal cycle: velocity ← acc + this cycle's delta, acc ← 0, vel_valid = 1.
- Velocity excludes index and clr clears. clr does not touch velocity or the window.

## Timing
- Reset values: count 0, dir 0, step 0, err 0, idx_latch 0, idx_seen 0, velocity 0, vel_valid 0.
- Also reset: filtered A/B/Z = 0, P = 00, sync FFs 0, window counter 0, acc 0.
- Latency: a raw edge stable before posedge n gives a registered count/step change at posedge n+FILT_LEN+2.
- Inputs must be held ≥FILT_LEN+4 cycles per state for guaranteed counting.
- Pulses shorter than FILT_LEN synced cycles are rejected.
- step and vel_valid are high for exactly one cycle.
- First vel_valid occurs VEL_PERIOD cycles after reset release, then every VEL_PERIOD cycles.
- clr takes effect at the next posedge. Asynchronous reset mid-operation returns everything to reset values immediately.

## Test plan
- Default params, mode 00, one forward cycle 01,11,10,00 (hold 8 cycles each) → count 0→4, dir = 1, four step pulses. Reverse sequence → count 4→0, dir = 0.
- Mode 01, 8 forward cycles → count +16. Mode 10, 8 forward then 8 backward cycles → count +8 then back to start. dir toggles on uncounted transitions.
- Glitch of 2 cycles on A → no count change. A and B changed simultaneously (00→11) → err = 1, count unchanged. clr → err = 0, count = 0.
- Count at 0xFFFF, one forward step → 0x0000. Backward step → 0xFFFF.
- Z rising edge at count 37 with idx_clr_en = 1 → idx_latch = 37, idx_seen = 1, count = 0. Z edge coincident with a forward step → count 0.
- VEL_PERIOD = 200, 5 forward cycles inside one window → vel_valid pulse with velocity = 20. Next idle window → velocity = 0.
